// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC-3 memory sequencer: operation codes and FSM states.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        OP_LD  = 2'b00,
        OP_LDI = 2'b01,
        OP_ST  = 2'b10,
        OP_STI = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MAR_A  = 3'd1,
        ST_MAR_I  = 3'd2,
        ST_READ   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    // Bit 0 of the opcode selects indirect addressing, bit 1 selects a store.
    function automatic logic op_indirect(input op_t op);
        return op[0];
    endfunction

    function automatic logic op_store(input op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/lc3_mem_seq.sv
// LC-3 memory sequencer: drives MAR/WE handshakes to an external memory for
// LD/LDI/ST/STI and keeps the last load result in MDR (RDATA).
module lc3_mem_seq
    import lc3_mem_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic [1:0]  OP,
    input  logic [15:0] ADDR,
    input  logic [15:0] WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] RDATA,
    output logic        MAR_LE,
    output logic        MAR_CONTROL,
    output logic        WE,
    output logic [15:0] Y,
    output logic [15:0] RD_DATA,
    input  logic [15:0] DATA
);

    state_t      state_reg;
    state_t      state_next;
    op_t         op_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
            op_q      <= OP_LD;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            rdata_q   <= 16'h0000;
        end else begin
            state_reg <= state_next;
            // Operands are captured only on acceptance, so inputs may change while busy.
            if (state_reg == ST_IDLE && REQ) begin
                op_q    <= op_t'(OP);
                addr_q  <= ADDR;
                wdata_q <= WDATA;
            end
            if (state_reg == ST_READ) begin
                rdata_q <= DATA;
            end
        end
    end

    // Outputs decode from the registered state only, so reset clears them at once.
    always_comb begin
        state_next  = state_reg;
        BUSY        = 1'b1;
        DONE        = 1'b0;
        MAR_LE      = 1'b0;
        MAR_CONTROL = 1'b0;
        WE          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                BUSY = 1'b0;
                if (REQ) begin
                    state_next = ST_MAR_A;
                end
            end
            ST_MAR_A: begin
                MAR_LE = 1'b1;
                if (op_indirect(op_q)) begin
                    state_next = ST_MAR_I;
                end else if (op_store(op_q)) begin
                    state_next = ST_WRITE;
                end else begin
                    state_next = ST_READ;
                end
            end
            ST_MAR_I: begin
                // MAR reloads from memory output: the pointer stored at addr_q.
                MAR_LE      = 1'b1;
                MAR_CONTROL = 1'b1;
                state_next  = op_store(op_q) ? ST_WRITE : ST_READ;
            end
            ST_READ: begin
                state_next = ST_FINISH;
            end
            ST_WRITE: begin
                WE         = 1'b1;
                state_next = ST_FINISH;
            end
            ST_FINISH: begin
                DONE       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                BUSY       = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign Y       = addr_q;
    assign RD_DATA = wdata_q;
    assign RDATA   = rdata_q;

endmodule
